// File: rtl/m_pc_sequencer.sv
// Program-counter sequencer: picks the next fetch PC from sequential, branch, jump,
// call/return, exception and exception-return sources, with a circular return-address stack.
module m_pc_sequencer #(
  parameter int               XLEN      = 32,
  parameter int               BR_OFF_W  = 13,
  parameter int               RAS_DEPTH = 4,
  parameter logic [XLEN-1:0]  RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0]  EXC_VEC   = 32'h0FFF_FFF0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch,
  input  logic [BR_OFF_W-1:0] branch_off,
  input  logic                jump,
  input  logic                call,
  input  logic [XLEN-3:0]     jump_target,
  input  logic                ret,
  input  logic                exc,
  input  logic                eret,
  output logic [XLEN-1:0]     pc_out,
  output logic [XLEN-1:0]     epc_out,
  output logic                in_exc,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_ovf,
  output logic                dbl_fault
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            in_exc_q, in_exc_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            empty_q, full_q;
  logic            ovf_q, ovf_d;
  logic            dbl_q, dbl_d;

  logic            ras_we;
  logic            take_exc;
  logic            cnt_full;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_off_ext;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jmp_pc;

  assign pc_plus4   = pc_q + XLEN'(4);
  assign br_off_ext = {{(XLEN-BR_OFF_W){branch_off[BR_OFF_W-1]}}, branch_off};
  assign br_target  = pc_q + (br_off_ext << 2);
  assign jmp_pc     = {jump_target, 2'b00};
  assign cnt_full   = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
    top_d    = top_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    dbl_d    = dbl_q;
    ras_we   = 1'b0;
    take_exc = 1'b0;
    if (exc) begin
      take_exc = 1'b1;
    end else if (eret) begin
      if (in_exc_q) begin
        pc_d     = epc_q;
        in_exc_d = 1'b0;
      end else begin
        pc_d = pc_plus4;
      end
    end else if (stall) begin
      pc_d = pc_q;
    end else if (branch) begin
      pc_d = br_target;
    end else if (ret) begin
      // A return with nothing to pop is an error and vectors like an exception.
      if (cnt_q != '0) begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else begin
        take_exc = 1'b1;
      end
    end else if (call) begin
      pc_d   = jmp_pc;
      top_d  = top_q + PW'(1);
      ras_we = 1'b1;
      if (cnt_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + CW'(1);
    end else if (jump) begin
      pc_d = jmp_pc;
    end else begin
      pc_d = pc_plus4;
    end

    if (take_exc) begin
      pc_d = EXC_VEC;
      if (!in_exc_q) begin
        epc_d    = pc_q;
        in_exc_d = 1'b1;
      end else begin
        dbl_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      in_exc_q <= 1'b0;
      top_q    <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbl_q    <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
      top_q    <= top_d;
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (cnt_d == CW'(RAS_DEPTH));
      ovf_q    <= ovf_d;
      dbl_q    <= dbl_d;
      // The pushed slot is the new top; when full this lands on the oldest entry.
      if (ras_we) ras_q[top_d] <= pc_plus4;
    end
  end

  assign pc_out    = pc_q;
  assign epc_out   = epc_q;
  assign in_exc    = in_exc_q;
  assign ras_empty = empty_q;
  assign ras_full  = full_q;
  assign ras_ovf   = ovf_q;
  assign dbl_fault = dbl_q;

endmodule

// File: tb/tb_m_pc_sequencer.sv
// Directed bench for m_pc_sequencer: one task per scenario, inline checks, pass/total summary.
module tb_m_pc_sequencer;

  localparam logic [31:0] EXC_VEC = 32'h0FFF_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, jump, call, ret, exc, eret;
  logic [12:0] branch_off;
  logic [29:0] jump_target;
  logic [31:0] pc_out, epc_out;
  logic        in_exc, ras_empty, ras_full, ras_ovf, dbl_fault;

  int n_checks = 0;
  int n_pass   = 0;

  m_pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_off(branch_off),
    .jump(jump), .call(call), .jump_target(jump_target), .ret(ret), .exc(exc), .eret(eret),
    .pc_out(pc_out), .epc_out(epc_out), .in_exc(in_exc), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .dbl_fault(dbl_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout pc=%h", pc_out);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    stall = 0; branch = 0; jump = 0; call = 0; ret = 0; exc = 0; eret = 0;
    branch_off = '0; jump_target = '0;
  endtask

  // One rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    idle();
    jump = 1; jump_target = addr[31:2];
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    step();
    n_checks++; if (pc_out !== 32'h0) $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); else n_pass++;
    n_checks++; if (epc_out !== 32'h0) $display("FAIL reset_epc got %h exp %h", epc_out, 32'h0); else n_pass++;
    n_checks++; if ({in_exc, ras_empty, ras_full, ras_ovf, dbl_fault} !== 5'b01000)
      $display("FAIL reset_flags got %b exp %b", {in_exc, ras_empty, ras_full, ras_ovf, dbl_fault}, 5'b01000); else n_pass++;
    reset = 1'b1;
    step();
    n_checks++; if (pc_out !== 32'h4) $display("FAIL seq_1 got %h exp %h", pc_out, 32'h4); else n_pass++;
    step();
    n_checks++; if (pc_out !== 32'h8) $display("FAIL seq_2 got %h exp %h", pc_out, 32'h8); else n_pass++;
    step();
    n_checks++; if (pc_out !== 32'hC) $display("FAIL seq_3 got %h exp %h", pc_out, 32'hC); else n_pass++;
    call = 1; jump_target = 30'h40;
    step();
    idle();
    n_checks++; if (ras_empty !== 1'b0) $display("FAIL call_nonempty got %b exp %b", ras_empty, 1'b0); else n_pass++;
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (pc_out !== 32'h0) $display("FAIL async_reset_pc got %h exp %h", pc_out, 32'h0); else n_pass++;
    n_checks++; if (ras_empty !== 1'b1) $display("FAIL async_reset_empty got %b exp %b", ras_empty, 1'b1); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_branch();
    pulse_reset();
    goto_pc(32'h100);
    n_checks++; if (pc_out !== 32'h100) $display("FAIL jump_0x100 got %h exp %h", pc_out, 32'h100); else n_pass++;
    branch = 1; branch_off = 13'h1FFE;
    step();
    n_checks++; if (pc_out !== 32'hF8) $display("FAIL branch_neg got %h exp %h", pc_out, 32'hF8); else n_pass++;
    stall = 1;
    step();
    n_checks++; if (pc_out !== 32'hF8) $display("FAIL stall_1 got %h exp %h", pc_out, 32'hF8); else n_pass++;
    step();
    n_checks++; if (pc_out !== 32'hF8) $display("FAIL stall_2 got %h exp %h", pc_out, 32'hF8); else n_pass++;
    stall = 0; branch_off = 13'h0004;
    step();
    n_checks++; if (pc_out !== 32'h108) $display("FAIL branch_pos got %h exp %h", pc_out, 32'h108); else n_pass++;
    branch_off = 13'h0001;
    step();
    step();
    n_checks++; if (pc_out !== 32'h110) $display("FAIL branch_held got %h exp %h", pc_out, 32'h110); else n_pass++;
    idle();
    branch = 1; branch_off = 13'h1000; call = 1; jump_target = 30'h3;
    step();
    idle();
    n_checks++; if (pc_out !== 32'hFFFF_C110) $display("FAIL branch_over_call got %h exp %h", pc_out, 32'hFFFF_C110); else n_pass++;
    n_checks++; if (ras_empty !== 1'b1) $display("FAIL call_dropped got %b exp %b", ras_empty, 1'b1); else n_pass++;
  endtask

  task automatic test_call_ret();
    pulse_reset();
    goto_pc(32'h40);
    call = 1; jump_target = 30'h100;
    step();
    idle();
    n_checks++; if (pc_out !== 32'h400) $display("FAIL call_pc got %h exp %h", pc_out, 32'h400); else n_pass++;
    ret = 1;
    step();
    n_checks++; if (pc_out !== 32'h44) $display("FAIL ret_pc got %h exp %h", pc_out, 32'h44); else n_pass++;
    n_checks++; if (ras_empty !== 1'b1) $display("FAIL ret_empty got %b exp %b", ras_empty, 1'b1); else n_pass++;
    step();
    idle();
    n_checks++; if (pc_out !== EXC_VEC) $display("FAIL ret_underflow_pc got %h exp %h", pc_out, EXC_VEC); else n_pass++;
    n_checks++; if (epc_out !== 32'h44) $display("FAIL ret_underflow_epc got %h exp %h", epc_out, 32'h44); else n_pass++;
    n_checks++; if (in_exc !== 1'b1) $display("FAIL ret_underflow_inexc got %b exp %b", in_exc, 1'b1); else n_pass++;
  endtask

  task automatic test_ras_overflow();
    logic [31:0] ra [5];
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      ra[i] = pc_out + 32'h4;
      call = 1; jump_target = 30'(32'h400 * (i + 1));
      step();
      idle();
      if (i == 3) begin
        n_checks++; if ({ras_full, ras_ovf} !== 2'b10) $display("FAIL ras_4_calls got %b exp %b", {ras_full, ras_ovf}, 2'b10); else n_pass++;
      end
    end
    n_checks++; if ({ras_full, ras_ovf} !== 2'b11) $display("FAIL ras_5_calls got %b exp %b", {ras_full, ras_ovf}, 2'b11); else n_pass++;
    n_checks++; if (ra[4] !== 32'h4004) $display("FAIL ras_a5_addr got %h exp %h", ra[4], 32'h4004); else n_pass++;
    for (int i = 4; i >= 1; i--) begin
      ret = 1;
      step();
      idle();
      n_checks++; if (pc_out !== ra[i]) $display("FAIL ras_pop_%0d got %h exp %h", i, pc_out, ra[i]); else n_pass++;
    end
    n_checks++; if ({ras_empty, ras_full, ras_ovf} !== 3'b101)
      $display("FAIL ras_drained got %b exp %b", {ras_empty, ras_full, ras_ovf}, 3'b101); else n_pass++;
  endtask

  task automatic test_exception();
    pulse_reset();
    goto_pc(32'h80);
    exc = 1; stall = 1; branch = 1; branch_off = 13'h0010;
    step();
    idle();
    n_checks++; if (pc_out !== EXC_VEC) $display("FAIL exc_pc got %h exp %h", pc_out, EXC_VEC); else n_pass++;
    n_checks++; if (epc_out !== 32'h80) $display("FAIL exc_epc got %h exp %h", epc_out, 32'h80); else n_pass++;
    n_checks++; if ({in_exc, dbl_fault} !== 2'b10) $display("FAIL exc_flags got %b exp %b", {in_exc, dbl_fault}, 2'b10); else n_pass++;
    step();
    exc = 1;
    step();
    idle();
    n_checks++; if (dbl_fault !== 1'b1) $display("FAIL dbl_fault got %b exp %b", dbl_fault, 1'b1); else n_pass++;
    n_checks++; if (epc_out !== 32'h80) $display("FAIL dbl_epc got %h exp %h", epc_out, 32'h80); else n_pass++;
    eret = 1; stall = 1;
    step();
    idle();
    n_checks++; if (pc_out !== 32'h80) $display("FAIL eret_pc got %h exp %h", pc_out, 32'h80); else n_pass++;
    n_checks++; if ({in_exc, dbl_fault} !== 2'b01) $display("FAIL eret_flags got %b exp %b", {in_exc, dbl_fault}, 2'b01); else n_pass++;
  endtask

  task automatic test_eret_seq_wrap();
    pulse_reset();
    goto_pc(32'h20);
    eret = 1;
    step();
    idle();
    n_checks++; if (pc_out !== 32'h24) $display("FAIL eret_noexc got %h exp %h", pc_out, 32'h24); else n_pass++;
    n_checks++; if (in_exc !== 1'b0) $display("FAIL eret_noexc_flag got %b exp %b", in_exc, 1'b0); else n_pass++;
    goto_pc(32'hFFFF_FFFC);
    step();
    n_checks++; if (pc_out !== 32'h0) $display("FAIL seq_wrap got %h exp %h", pc_out, 32'h0); else n_pass++;
    call = 1; jump_target = 30'h3FFF_FFFF;
    step();
    idle();
    n_checks++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL call_top got %h exp %h", pc_out, 32'hFFFF_FFFC); else n_pass++;
    call = 1; jump_target = 30'h10;
    step();
    idle();
    ret = 1;
    step();
    idle();
    n_checks++; if (pc_out !== 32'h0) $display("FAIL ret_wrapped got %h exp %h", pc_out, 32'h0); else n_pass++;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #2;
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_exception();
    test_eret_seq_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
